// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-stage CPU pipeline control path.
`default_nettype none

package cpu_pkg;

  localparam int REG_ADDR_W = 5;

  // Instruction word loaded into a pipeline register on a bubble or flush.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_control_unit_load_use_detector.sv
// Load-use hazard detection: a load in EX_MEM whose result an ID source needs.
`default_nettype none

module load_use_detector
  import cpu_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] ID_rA,
  input  logic [REG_ADDR_W-1:0] ID_rB,
  input  logic                  ID_useA,
  input  logic                  ID_useB,
  input  logic [REG_ADDR_W-1:0] EX_MEM_rD,
  input  logic                  EX_MEM_wrEn,
  input  logic                  EX_MEM_load,
  output logic                  load_use
);

  logic match_a;
  logic match_b;

  assign match_a  = ID_useA & (ID_rA == EX_MEM_rD);
  assign match_b  = ID_useB & (ID_rB == EX_MEM_rD);
  // r0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = EX_MEM_load & EX_MEM_wrEn & (EX_MEM_rD != '0) & (match_a | match_b);

endmodule

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: stage enables, bubbles, flushes, memory-wait freeze and
// timeout, plus a saturating stall-cycle counter.
`default_nettype none

module hazard_control_unit
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ID_rA,
  input  logic [REG_ADDR_W-1:0] ID_rB,
  input  logic                  ID_useA,
  input  logic                  ID_useB,
  input  logic                  ID_branch_taken,
  input  logic [REG_ADDR_W-1:0] EX_MEM_rD,
  input  logic                  EX_MEM_wrEn,
  input  logic                  EX_MEM_load,
  input  logic                  EX_MEM_memEn,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  pc_wrEn,
  output logic                  pc_sel_branch,
  output logic                  IF_ID_wrEn,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_MEM_wrEn,
  output logic                  ID_EX_MEM_bubble,
  output logic                  EX_MEM_WB_wrEn,
  output logic                  EX_MEM_WB_bubble,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                load_use;
  logic                timeout;
  logic                freeze;

  load_use_detector u_load_use_detector (
    .ID_rA       (ID_rA),
    .ID_rB       (ID_rB),
    .ID_useA     (ID_useA),
    .ID_useB     (ID_useB),
    .EX_MEM_rD   (EX_MEM_rD),
    .EX_MEM_wrEn (EX_MEM_wrEn),
    .EX_MEM_load (EX_MEM_load),
    .load_use    (load_use)
  );

  assign timeout = (state == MEM_WAIT) & ~mem_ack & (wait_cnt == WAIT_W'(TIMEOUT_CYCLES));
  // A timeout releases the freeze exactly like an ack would.
  assign freeze  = (state == RUN)      ? (EX_MEM_memEn & ~mem_ack)
                                       : (~mem_ack & ~timeout);

  always_comb begin
    mem_req          = 1'b0;
    pc_wrEn          = 1'b1;
    pc_sel_branch    = 1'b0;
    IF_ID_wrEn       = 1'b1;
    IF_ID_flush      = 1'b0;
    ID_EX_MEM_wrEn   = 1'b1;
    ID_EX_MEM_bubble = 1'b0;
    EX_MEM_WB_wrEn   = 1'b1;
    EX_MEM_WB_bubble = 1'b0;
    if (reset) begin
      pc_wrEn          = 1'b0;
      IF_ID_wrEn       = 1'b0;
      IF_ID_flush      = 1'b1;
      ID_EX_MEM_wrEn   = 1'b0;
      ID_EX_MEM_bubble = 1'b1;
      EX_MEM_WB_wrEn   = 1'b0;
      EX_MEM_WB_bubble = 1'b1;
    end else begin
      mem_req = EX_MEM_memEn;
      if (freeze) begin
        pc_wrEn          = 1'b0;
        IF_ID_wrEn       = 1'b0;
        ID_EX_MEM_wrEn   = 1'b0;
        EX_MEM_WB_wrEn   = 1'b0;
        EX_MEM_WB_bubble = 1'b1;
      end else if (load_use) begin
        // A branch seen alongside the hazard re-resolves once the load has moved on.
        pc_wrEn          = 1'b0;
        IF_ID_wrEn       = 1'b0;
        ID_EX_MEM_bubble = 1'b1;
      end else if (ID_branch_taken) begin
        pc_sel_branch = 1'b1;
        IF_ID_flush   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (!pc_wrEn && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (EX_MEM_memEn && !mem_ack) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (timeout) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
